psum_drain: RTL

- Consumer end of the compute array's psum interface: snapshots the full ROWSxCOLS partial-sum array on a capture request.
- Serializes the snapshot row-major onto a valid/ready stream, one psum per beat, toward the output buffer / writeback path.
- Decouples the array from downstream so the array can start the next tile while the previous tile drains.

---
 rtl/psum_drain_if.sv | 35 +++
 rtl/psum_drain.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/psum_drain_if.sv
// Output stream of psum_drain: one psum per beat with its array coordinates.
// The master drives data/indices/valid, the slave returns ready.
interface psum_drain_if #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int PSUM_W = 32
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic              out_valid;
    logic              out_ready;
    logic [PSUM_W-1:0] out_data;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/psum_drain.sv
// Snapshots the ROWSxCOLS psum array and drains it row-major on a stream.
// Optional PSUM_DRAIN_RELU_EN clamps negative psums to zero on the output.
module psum_drain #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int PSUM_W = 32
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        cap_req,
    input  logic [ROWS*COLS*PSUM_W-1:0] psums_in,
    output logic                        cap_ack,
    output logic                        cap_overrun,
    output logic                        busy,
    psum_drain_if.master                out
);
    localparam int N     = ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              ack_q, ack_d;
    logic              ovr_q, ovr_d;
    logic [PSUM_W-1:0] snap_q [N];
    logic [PSUM_W-1:0] snap_d [N];

    logic              load;
    logic              xfer;
    logic              at_last;
    logic [IDX_W-1:0]  idx;
    logic [PSUM_W-1:0] elem;
    logic [PSUM_W-1:0] beat_data;

    assign xfer    = (state_q == DRAIN) && out.out_ready;
    assign at_last = (row_q == ROW_MAX) && (col_q == COL_MAX);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ack_q   <= ack_d;
            ovr_q   <= ovr_d;
        end
    end

    // Snapshot contents survive reset; only the control path is cleared.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            snap_q[i] <= snap_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            snap_d[i] = load ? psums_in[i*PSUM_W +: PSUM_W] : snap_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        ack_d   = 1'b0;
        ovr_d   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cap_req) begin
                    load    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = DRAIN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (at_last) begin
                        row_d = '0;
                        col_d = '0;
                        // Capture on the final transfer keeps the stream gapless.
                        if (cap_req) begin
                            load  = 1'b1;
                            ack_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                if (cap_req && !(xfer && at_last)) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
        elem = snap_q[idx];
`ifdef PSUM_DRAIN_RELU_EN
        beat_data = elem[PSUM_W-1] ? '0 : elem;
`else
        beat_data = elem;
`endif
    end

    always_comb begin
        busy          = (state_q == DRAIN);
        out.out_valid = busy;
        out.out_data  = busy ? beat_data : '0;
        out.out_row   = row_q;
        out.out_col   = col_q;
        out.out_last  = busy && at_last;
        cap_ack       = ack_q;
        cap_overrun   = ovr_q;
    end
endmodule
